// File: rtl/tri_state_buf_pkg.sv
// -----------------------------------------------------------------------------
// tri_state_buf_pkg
// Shared definitions for the registered tri-state bus driver:
//   - state_t : controller states (IDLE, DRIVE, TURN)
//   - CTR_W   : width of the turnaround down-counter (covers 0..15)
// -----------------------------------------------------------------------------
package tri_state_buf_pkg;

  localparam int CTR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/tri_state_buf_turn_ctr.sv
// -----------------------------------------------------------------------------
// tri_state_buf_turn_ctr
// Loadable down-counter with a zero flag. It times the high-Z turnaround
// window between releasing the bus and accepting a new drive request.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (count cleared to 0)
//   i_load     load i_loadVal on the next edge (has priority over i_dec)
//   i_loadVal  value to load
//   i_dec      decrement on the next edge; the count saturates at zero
//   o_zero     high while the count is zero
// -----------------------------------------------------------------------------
module tri_state_buf_turn_ctr
  import tri_state_buf_pkg::*;
#(
  parameter int W = CTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over decrement; decrementing a zero count leaves it at zero so
  // a stray decrement request can never wrap the window to its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/tri_state_buf.sv
// -----------------------------------------------------------------------------
// tri_state_buf
// Registered, parameterisable-width tri-state bus driver with a controlled
// turnaround window. While enabled, the captured data_in is driven onto the
// shared bus; otherwise the output is released to high-Z and the resolved bus
// is sampled into bus_q.
//
// Parameters:
//   WIDTH       data/bus width in bits (>= 1)
//   TURNAROUND  high-Z cycles inserted after enable drops before a new drive
//               is accepted (0..15)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   enable    drive request, sampled on clk (X treated as 0)
//   data_in   data to drive onto the bus
//   data_out  tri-state bus output: registered drive value or all-Z
//   bus_in    resolved bus value, read back
//   bus_q     last bus value sampled while not driving
//   driving   high while data_out is actively driven
//   busy      high during the turnaround window
//
// Optional feature (macro TRI_STATE_BUF_CONTENTION_CHECK_EN):
//   contention  sticky flag, set when another driver fights the bus while
//               this block is driving; cleared only by reset.
// -----------------------------------------------------------------------------
module tri_state_buf
  import tri_state_buf_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output wire  [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_q,
  output logic             driving,
  output logic             busy
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
  ,
  output logic             contention
`endif
);

  localparam int TURN_LOAD_INT = (TURNAROUND > 0) ? (TURNAROUND - 1) : 0;
  localparam logic [CTR_W-1:0] TURN_LOAD = TURN_LOAD_INT[CTR_W-1:0];

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_outQ;
  logic [WIDTH-1:0] r_busQ;
  logic             w_ctrLoad;
  logic             w_ctrDec;
  logic             w_ctrZero;
  logic             w_capture;

  tri_state_buf_turn_ctr #(
    .W (CTR_W)
  ) u_turnCtr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_ctrLoad),
    .i_loadVal (TURN_LOAD),
    .i_dec     (w_ctrDec),
    .o_zero    (w_ctrZero)
  );

  // Next-state logic. An X on enable falls through to the else branches,
  // so an unknown request never starts or holds a drive.
  always_comb begin
    w_nextState = r_state;
    w_ctrLoad   = 1'b0;
    w_ctrDec    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_nextState = DRIVE;
        end
      end
      DRIVE: begin
        if (enable) begin
          w_nextState = DRIVE;
        end else if (TURNAROUND > 0) begin
          w_nextState = TURN;
          w_ctrLoad   = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      TURN: begin
        // enable is deliberately ignored here; a held request is picked up
        // on the first edge back in IDLE.
        if (w_ctrZero) begin
          w_nextState = IDLE;
        end else begin
          w_ctrDec = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Data is captured exactly on edges that lead into DRIVE, which covers both
  // the initial acceptance from IDLE and tracking while already driving.
  assign w_capture = (w_nextState == DRIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outQ <= '0;
    end else if (w_capture) begin
      r_outQ <= data_in;
    end
  end

  // The bus is only worth sampling when someone else may own it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busQ <= '0;
    end else if (r_state != DRIVE) begin
      r_busQ <= bus_in;
    end
  end

`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
  logic r_contention;

  // Equality against X/Z bits is unknown and falls into the else branch,
  // so undriven or fighting bits count as contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contention <= 1'b0;
    end else if (r_state == DRIVE) begin
      if (bus_in == r_outQ) begin
        r_contention <= r_contention;
      end else begin
        r_contention <= 1'b1;
      end
    end
  end

  assign contention = r_contention;
`endif

  // Output enable comes straight from the state register so an asynchronous
  // reset releases the bus without waiting for a clock edge.
  assign data_out = (r_state == DRIVE) ? r_outQ : {WIDTH{1'bz}};
  assign bus_q    = r_busQ;
  assign driving  = (r_state == DRIVE);
  assign busy     = (r_state == TURN);

endmodule

// File: tb/tb_tri_state_buf.sv
// -----------------------------------------------------------------------------
// tb_tri_state_buf
// Directed bench for tri_state_buf. Three instances cover TURNAROUND = 1, 3
// and 0. Each data_out net also has a bench-side driver that puts a known
// pattern on the net whenever the DUT is expected to be released, so a
// high-Z output is observed as that pattern on the resolved net.
// -----------------------------------------------------------------------------
module tb_tri_state_buf;

  localparam logic [31:0] PULLV = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataIn;
  logic        en1, en3, en0;
  logic [31:0] bIn1, bIn3, bIn0;
  wire  [31:0] out1, out3, out0;
  logic [31:0] q1, q3, q0;
  logic        drv1, drv3, drv0;
  logic        busy1, busy3, busy0;
  logic        tbDrv1, tbDrv3, tbDrv0;
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
  logic        cont1, cont3, cont0;
`endif

  int errors = 0;
  int checks = 0;

  // Bench-side resolver: fills the bus when the DUT is expected to be off it.
  assign out1 = tbDrv1 ? PULLV : 32'hzzzz_zzzz;
  assign out3 = tbDrv3 ? PULLV : 32'hzzzz_zzzz;
  assign out0 = tbDrv0 ? PULLV : 32'hzzzz_zzzz;

  tri_state_buf #(.WIDTH(32), .TURNAROUND(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .enable (en1), .data_in (dataIn),
    .data_out (out1), .bus_in (bIn1), .bus_q (q1), .driving (drv1),
    .busy (busy1)
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    , .contention (cont1)
`endif
  );

  tri_state_buf #(.WIDTH(32), .TURNAROUND(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .enable (en3), .data_in (dataIn),
    .data_out (out3), .bus_in (bIn3), .bus_q (q3), .driving (drv3),
    .busy (busy3)
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    , .contention (cont3)
`endif
  );

  tri_state_buf #(.WIDTH(32), .TURNAROUND(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .enable (en0), .data_in (dataIn),
    .data_out (out0), .bus_in (bIn0), .bus_q (q0), .driving (drv0),
    .busy (busy0)
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    , .contention (cont0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances the given number of rising edges and settles 1 time unit later.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed,
                          input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en1    = 1'b1;
    en3    = 1'b1;
    en0    = 1'b1;
    dataIn = 32'h00FF_00FF;
    bIn1   = '0;
    bIn3   = '0;
    bIn0   = '0;
    tbDrv1 = 1'b1;
    tbDrv3 = 1'b1;
    tbDrv0 = 1'b1;

    // Reset held with enable high: bus stays released
    #2;
    checkOutput("rst_out1", out1, PULLV);
    checkBit   ("rst_drv1", drv1, 1'b0);
    checkBit   ("rst_busy1", busy1, 1'b0);
    checkOutput("rst_q1", q1, 32'h0);
    applyStimulus(2);
    checkOutput("rst_hold_out1", out1, PULLV);
    checkOutput("rst_hold_out3", out3, PULLV);
    checkOutput("rst_hold_out0", out0, PULLV);
    checkBit   ("rst_hold_drv1", drv1, 1'b0);
    checkOutput("rst_hold_q1", q1, 32'h0);
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    checkBit   ("rst_cont1", cont1, 1'b0);
`endif

    // Release reset, idle two cycles
    en1 = 1'b0;
    en3 = 1'b0;
    en0 = 1'b0;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("idle_out1", out1, PULLV);
    checkBit   ("idle_drv1", drv1, 1'b0);

    // Bus sampling in IDLE
    bIn1 = 32'hFF00_FF00;
    applyStimulus(1);
    checkOutput("idle_sample_q1", q1, 32'hFF00_FF00);

    // Drive request: still released until the edge samples enable
    en1 = 1'b1;
    dataIn = 32'h00FF_00FF;
    #1;
    checkOutput("pre_drive_out1", out1, PULLV);
    tbDrv1 = 1'b0;
    applyStimulus(1);
    checkOutput("drive_out1", out1, 32'h00FF_00FF);
    checkBit   ("drive_drv1", drv1, 1'b1);
    checkBit   ("drive_busy1", busy1, 1'b0);

    // Tracking with one-edge latency; bus_q holds while driving
    bIn1 = 32'h1234_5678;
    dataIn = 32'hFF00_FF00;
    #1;
    checkOutput("track_before_out1", out1, 32'h00FF_00FF);
    applyStimulus(1);
    checkOutput("track_after_out1", out1, 32'hFF00_FF00);
    checkOutput("drive_hold_q1", q1, 32'hFF00_FF00);
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    checkBit   ("cont1_set", cont1, 1'b1);
`endif

    // Release with TURNAROUND=1: one busy cycle, then IDLE
    en1 = 1'b0;
    tbDrv1 = 1'b1;
    applyStimulus(1);
    checkOutput("turn1_out1", out1, PULLV);
    checkBit   ("turn1_busy1", busy1, 1'b1);
    checkBit   ("turn1_drv1", drv1, 1'b0);
    bIn1 = 32'h0000_AAAA;
    applyStimulus(1);
    checkBit   ("turn1_done_busy1", busy1, 1'b0);
    checkBit   ("turn1_done_drv1", drv1, 1'b0);
    checkOutput("turn1_done_out1", out1, PULLV);
    checkOutput("turn_sample_q1", q1, 32'h0000_AAAA);
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    checkBit   ("cont1_sticky", cont1, 1'b1);
`endif

    // Asynchronous reset in the middle of a drive cycle
    en1 = 1'b1;
    tbDrv1 = 1'b0;
    applyStimulus(1);
    checkBit   ("redrive_drv1", drv1, 1'b1);
    checkOutput("redrive_out1", out1, 32'hFF00_FF00);
    #3;
    tbDrv1 = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out1", out1, PULLV);
    checkBit   ("async_rst_drv1", drv1, 1'b0);
    checkOutput("async_rst_q1", q1, 32'h0);
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    checkBit   ("cont1_cleared", cont1, 1'b0);
`endif
    #2;
    en1 = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1);

    // TURNAROUND=3: three busy cycles, drive resumes on first IDLE edge
    en3 = 1'b1;
    dataIn = 32'h00FF_00FF;
    bIn3 = 32'h00FF_00FF;
    tbDrv3 = 1'b0;
    applyStimulus(1);
    checkOutput("t3_drive_out3", out3, 32'h00FF_00FF);
    checkBit   ("t3_drive_drv3", drv3, 1'b1);
    applyStimulus(1);
`ifdef TRI_STATE_BUF_CONTENTION_CHECK_EN
    checkBit   ("cont3_match", cont3, 1'b0);
`endif
    en3 = 1'b0;
    tbDrv3 = 1'b1;
    applyStimulus(1);
    checkBit   ("t3_turn_a_busy3", busy3, 1'b1);
    checkOutput("t3_turn_a_out3", out3, PULLV);
    en3 = 1'b1;
    applyStimulus(1);
    checkBit   ("t3_turn_b_busy3", busy3, 1'b1);
    checkBit   ("t3_turn_b_drv3", drv3, 1'b0);
    applyStimulus(1);
    checkBit   ("t3_turn_c_busy3", busy3, 1'b1);
    applyStimulus(1);
    checkBit   ("t3_idle_busy3", busy3, 1'b0);
    checkBit   ("t3_idle_drv3", drv3, 1'b0);
    checkOutput("t3_idle_out3", out3, PULLV);
    tbDrv3 = 1'b0;
    applyStimulus(1);
    checkBit   ("t3_resume_drv3", drv3, 1'b1);
    checkOutput("t3_resume_out3", out3, 32'h00FF_00FF);

    // TURNAROUND=0: DRIVE -> IDLE -> DRIVE, one released cycle, never busy
    en0 = 1'b1;
    dataIn = 32'h0F0F_0F0F;
    tbDrv0 = 1'b0;
    applyStimulus(1);
    checkBit   ("t0_drive_drv0", drv0, 1'b1);
    checkOutput("t0_drive_out0", out0, 32'h0F0F_0F0F);
    en0 = 1'b0;
    tbDrv0 = 1'b1;
    applyStimulus(1);
    checkBit   ("t0_gap_drv0", drv0, 1'b0);
    checkBit   ("t0_gap_busy0", busy0, 1'b0);
    checkOutput("t0_gap_out0", out0, PULLV);
    en0 = 1'b1;
    tbDrv0 = 1'b0;
    applyStimulus(1);
    checkBit   ("t0_resume_drv0", drv0, 1'b1);

    // Unknown enable leaves DRIVE
    en0 = 1'bx;
    tbDrv0 = 1'b1;
    applyStimulus(1);
    checkBit   ("xen_drv0", drv0, 1'b0);
    checkOutput("xen_out0", out0, PULLV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
